// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and FSM state encoding for the register file / scoreboard slice.
package regfile_scoreboard_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [0:0] state_t;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/regfile_scoreboard_sb_busy.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module sb_busy #(
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [2*AW-1:0] iss_rs,
    output logic            stall,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             set_en;

    // A register still hazards only if busy and not retiring in this very cycle.
    function automatic logic pending(input logic [NREGS-1:0] b,
                                     input logic [AW-1:0]    r,
                                     input logic             wb,
                                     input logic [AW-1:0]    wb_addr);
        pending = 1'b0;
        if (r != '0 && ({1'b0, r} < (AW+1)'(NREGS)))
            pending = b[r] && !(wb && wb_addr == r);
    endfunction

    always_comb begin
        stall = 1'b0;
        if (iss_valid) begin
            if (!run)
                stall = 1'b1;
            else
                stall = pending(busy, iss_rs[0 +: AW], we, wa)
                      | pending(busy, iss_rs[AW +: AW], we, wa)
                      | pending(busy, iss_rd, we, wa);
        end
    end

    assign set_en = iss_valid && !stall;

    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < NREGS; i++) begin
            if (we && wa == AW'(i))
                busy_nxt[i] = 1'b0;
            if (set_en && iss_rd == AW'(i))
                busy_nxt[i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write bypass, post-reset clear sweep and busy scoreboard.
// States: CLEAR | zeroing regs[sweep_cnt], one per cycle;  RUN | normal operation.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic [2*AW-1:0]     iss_rs,
    output logic                stall,
    output logic [NREGS-1:0]    busy_vec,
    output logic                init_done
);

    state_t          state;
    logic [AW-1:0]   sweep_cnt;
    logic [XLEN-1:0] regs [NREGS];
    logic            run;
    logic            wa_ok;

    assign run       = (state == ST_RUN);
    assign init_done = run;
    assign wa_ok     = ({1'b0, wa} < (AW+1)'(NREGS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == AW'(NREGS - 1))
                state <= ST_RUN;
        end
    end

    // Storage has no reset; the sweep is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR)
            regs[sweep_cnt] <= '0;
        else if (we && wa != '0 && wa_ok)
            regs[wa] <= wd;
    end

    always_comb begin
        rd = '0;
        for (int k = 0; k < NRD; k++) begin
            if (run && ra[k*AW +: AW] != '0) begin
                if (we && wa == ra[k*AW +: AW])
                    rd[k*XLEN +: XLEN] = wd;
                else if ({1'b0, ra[k*AW +: AW]} < (AW+1)'(NREGS))
                    rd[k*XLEN +: XLEN] = regs[ra[k*AW +: AW]];
            end
        end
    end

    sb_busy #(
        .NREGS (NREGS)
    ) u_sb_busy (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .we        (we && run),
        .wa        (wa),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_rs    (iss_rs),
        .stall     (stall),
        .busy_vec  (busy_vec)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed-vector bench for regfile_scoreboard: default config plus a 4-port 64-bit instance.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;

    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [9:0]  iss_rs;
    logic        stall;
    logic [31:0] busy_vec;
    logic        init_done;

    logic         w_we;
    logic [4:0]   w_wa;
    logic [63:0]  w_wd;
    logic [19:0]  w_ra;
    logic [255:0] w_rd;
    logic         w_iss_valid;
    logic [4:0]   w_iss_rd;
    logic [9:0]   w_iss_rs;
    logic         w_stall;
    logic [31:0]  w_busy;
    logic         w_init_done;

    int n_vec  = 0;
    int n_fail = 0;
    int n_cyc;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs(iss_rs),
        .stall(stall), .busy_vec(busy_vec), .init_done(init_done)
    );

    regfile_scoreboard #(.XLEN(64), .NRD(4)) dut_w (
        .clk(clk), .rst(rst), .we(w_we), .wa(w_wa), .wd(w_wd), .ra(w_ra), .rd(w_rd),
        .iss_valid(w_iss_valid), .iss_rd(w_iss_rd), .iss_rs(w_iss_rs),
        .stall(w_stall), .busy_vec(w_busy), .init_done(w_init_done)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  irs0;
        logic [4:0]  irs1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_stall;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_init(input string name);
        n_cyc = 0;
        while (!init_done && n_cyc < 40) begin
            @(posedge clk);
            #1;
            n_cyc++;
        end
        chk(name, 64'(n_cyc), 64'd32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[2]  = '{1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h80};
        vt[5]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd8, 5'd7, 5'd3, 32'h0, 32'h0, 1'b1, 32'h80};
        vt[6]  = '{1'b1, 5'd7, 32'h77, 5'd7, 5'd3, 1'b1, 5'd8, 5'd7, 5'd3, 32'h77, 32'h0, 1'b0, 32'h100};
        vt[7]  = '{1'b1, 5'd9, 32'h99, 5'd9, 5'd8, 1'b1, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 1'b0, 32'h300};
        vt[8]  = '{1'b1, 5'd9, 32'hAAA, 5'd9, 5'd7, 1'b1, 5'd9, 5'd0, 5'd0, 32'hAAA, 32'h77, 1'b0, 32'h300};
        vt[9]  = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd5, 1'b1, 5'd9, 5'd0, 5'd0, 32'hAAA, 32'hDEADBEEF, 1'b1, 32'h300};
        vt[10] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd9, 5'd8, 5'd9, 32'h0, 32'h0, 1'b0, 32'h300};
        vt[11] = '{1'b1, 5'd8, 32'h88, 5'd8, 5'd9, 1'b0, 5'd0, 5'd0, 5'd0, 32'h88, 32'hAAA, 1'b0, 32'h200};
        vt[12] = '{1'b1, 5'd9, 32'h1, 5'd9, 5'd7, 1'b0, 5'd0, 5'd0, 5'd0, 32'h1, 32'h77, 1'b0, 32'h0};
        vt[13] = '{1'b1, 5'd3, 32'h5, 5'd5, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 32'h5, 1'b0, 32'h0};
        vt[14] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 5'd0, 5'd3, 5'd5, 32'h5, 32'h0, 1'b0, 32'h0};

        rst = 1'b1;
        we = 1'b0; wa = '0; wd = '0; ra = '0;
        iss_valid = 1'b1; iss_rd = '0; iss_rs = '0;
        w_we = 1'b0; w_wa = '0; w_wd = '0; w_ra = '0;
        w_iss_valid = 1'b0; w_iss_rd = '0; w_iss_rs = '0;

        // Reset state and the length of the first sweep.
        @(posedge clk);
        #1;
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_busy", 64'(busy_vec), 64'd0);
        chk("rst_stall", 64'(stall), 64'd1);
        chk("rst_rd", rd, 64'd0);
        chk("rst_w_init_done", 64'(w_init_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ra = {5'd0, 5'd7};
        #1;
        chk("clear_stall", 64'(stall), 64'd1);
        chk("clear_rd", rd, 64'd0);
        iss_valid = 1'b0;
        #1;
        chk("clear_stall_idle", 64'(stall), 64'd0);
        wait_init("sweep_len");
        chk("w_init_done", 64'(w_init_done), 64'd1);

        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            ra = {5'(31 - a), 5'(a)};
            #1;
            chk($sformatf("swept_rd0_%0d", a), 64'(rd[31:0]), 64'd0);
            chk($sformatf("swept_rd1_%0d", a), 64'(rd[63:32]), 64'd0);
        end

        // Table-driven vectors on the default instance.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
            ra = {vt[i].ra1, vt[i].ra0};
            iss_valid = vt[i].iv; iss_rd = vt[i].ird;
            iss_rs = {vt[i].irs1, vt[i].irs0};
            #1;
            chk($sformatf("vec%0d_rd0", i), 64'(rd[31:0]), 64'(vt[i].e_rd0));
            chk($sformatf("vec%0d_rd1", i), 64'(rd[63:32]), 64'(vt[i].e_rd1));
            chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(vt[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_busy", i), 64'(busy_vec), 64'(vt[i].e_busy));
        end
        @(negedge clk);
        we = 1'b0; iss_valid = 1'b0; iss_rs = '0; iss_rd = '0; ra = '0;

        // WAW hazard on the 4-port 64-bit instance.
        w_iss_valid = 1'b1; w_iss_rd = 5'd12;
        #1;
        chk("w_issue12_stall", 64'(w_stall), 64'd0);
        @(posedge clk);
        #1;
        chk("w_busy12", 64'(w_busy), 64'h1000);
        @(negedge clk);
        #1;
        chk("w_waw_stall", 64'(w_stall), 64'd1);
        w_iss_valid = 1'b0;
        #1;
        chk("w_waw_idle_stall", 64'(w_stall), 64'd0);
        w_we = 1'b1; w_wa = 5'd12; w_wd = 64'h0123_4567_89AB_CDEF;
        w_ra = {5'd3, 5'd12, 5'd0, 5'd12};
        #1;
        chk("w_rd_p0", w_rd[63:0], 64'h0123_4567_89AB_CDEF);
        chk("w_rd_p1", w_rd[127:64], 64'd0);
        chk("w_rd_p2", w_rd[191:128], 64'h0123_4567_89AB_CDEF);
        chk("w_rd_p3", w_rd[255:192], 64'd0);
        @(posedge clk);
        #1;
        chk("w_busy_cleared", 64'(w_busy), 64'd0);
        @(negedge clk);
        w_we = 1'b0;
        #1;
        chk("w_rd_stored", w_rd[63:0], 64'h0123_4567_89AB_CDEF);

        // Reset landing mid-sweep restarts the clear from index 0.
        we = 1'b1; wa = 5'd20; wd = 32'hFF;
        iss_valid = 1'b1; iss_rd = 5'd4;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0; iss_valid = 1'b0; ra = {5'd0, 5'd20};
        #1;
        chk("r20_written", 64'(rd[31:0]), 64'hFF);
        chk("busy4_pre_rst", 64'(busy_vec), 64'h10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_busy", 64'(busy_vec), 64'd0);
        chk("rst2_init_done", 64'(init_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_sweep_init_done", 64'(init_done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        we = 1'b1; wa = 5'd20; wd = 32'h55;
        #1;
        chk("mid_sweep_rd", 64'(rd[31:0]), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        wait_init("resweep_len");
        @(negedge clk);
        ra = {5'd20, 5'd20};
        #1;
        chk("r20_cleared", rd, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
